hilbert_fir_filter: RTL and testbench

//  Hilbert-transform FIR stage directly downstream of the HT coefficient setup block.
//  - On enable: requests the coefficient stream, captures LENGTH taps, then filters
//    the input sample stream one sample per cycle.
//  - Emits the quadrature (Hilbert) output plus the group-delay-matched in-phase

---
 rtl/hilbert_fir_filter.sv | 214 +++++++++++++++++++++
 tb/tb_hilbert_fir_filter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_fir_filter.sv
// ---------------------------------------------------------------------------
// hilbert_fir_filter
//
// Purpose:
//   Hilbert-transform FIR stage that sits directly after the HT coefficient
//   setup block. When enabled it asks the setup block for the coefficient
//   stream and captures LENGTH taps. It then filters the input sample stream
//   at one sample per cycle. Each result is the quadrature (Hilbert) output
//   together with the in-phase sample delayed to match the group delay, so the
//   two outputs form the analytic signal.
//
// Parameters:
//   LENGTH      number of taps (odd, same as the coefficient setup block)
//   DATA_WIDTH  signed width of coefficients and samples
//   ACC_WIDTH   signed output width, >= 2*DATA_WIDTH + clog2(LENGTH)
//
// Ports:
//   clock           rising-edge clock
//   resetN          synchronous active-low reset
//   enable          run request; low returns the block to IDLE
//   coeffEnable     enable for the coefficient setup block
//   coeffIn         signed coefficient from the setup block
//   coeffSetFlag    setup block's last-coefficient flag
//   dataIn          signed input sample x[n]
//   dataInValid     sample qualifier, honoured only in RUN
//   dataOut         y[n] = sum coeff[k] * x[n-k]
//   dataDelayedOut  x[n-(LENGTH-1)/2], aligned with dataOut
//   dataOutValid    qualifies dataOut / dataDelayedOut
//   filterReady     high while in RUN
//   coeffError      sticky malformed-coefficient-stream flag
// ---------------------------------------------------------------------------
module hilbert_fir_filter #(
  parameter int LENGTH     = 27,
  parameter int DATA_WIDTH = 18,
  parameter int ACC_WIDTH  = 41
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         enable,
  output logic                         coeffEnable,
  input  logic signed [DATA_WIDTH-1:0] coeffIn,
  input  logic                         coeffSetFlag,
  input  logic signed [DATA_WIDTH-1:0] dataIn,
  input  logic                         dataInValid,
  output logic signed [ACC_WIDTH-1:0]  dataOut,
  output logic signed [DATA_WIDTH-1:0] dataDelayedOut,
  output logic                         dataOutValid,
  output logic                         filterReady,
  output logic                         coeffError
);

  localparam int CENTER = (LENGTH - 1) / 2;
  localparam int CNT_W  = $clog2(LENGTH + 1);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ERROR = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        loadCount_q, loadCount_d;
  logic                    coeffEnableD_q;
  logic                    coeffError_q, coeffError_d;
  logic                    captureEn;
  logic                    accept;

  logic signed [DATA_WIDTH-1:0] coeff_q [LENGTH];
  logic signed [DATA_WIDTH-1:0] tap_q   [LENGTH];
  logic signed [PROD_W-1:0]     prod_q  [LENGTH];
  logic signed [DATA_WIDTH-1:0] midTap_q;
  logic signed [ACC_WIDTH-1:0]  sum_d;
  logic signed [ACC_WIDTH-1:0]  dataOut_q;
  logic signed [DATA_WIDTH-1:0] dataDelayed_q;
  logic                         tapValid_q, prodValid_q, dataOutValid_q;

  // Control outputs decode straight from the registered state, so they change
  // only on clock edges and are zero whenever reset forces IDLE.
  assign coeffEnable    = (state_q == LOAD);
  assign filterReady    = (state_q == RUN);
  assign coeffError     = coeffError_q;
  assign dataOut        = dataOut_q;
  assign dataDelayedOut = dataDelayed_q;
  assign dataOutValid   = dataOutValid_q;

  // A sample is taken only in RUN; a falling enable aborts on the same edge.
  assign accept = (state_q == RUN) && enable && dataInValid;

  // Next-state logic. The setup block's output lags coeffEnable by one cycle,
  // so captures are qualified with the delayed enable. Dropping enable wins
  // over everything else and also suppresses a capture on that edge.
  always_comb begin
    state_d      = state_q;
    loadCount_d  = loadCount_q;
    coeffError_d = coeffError_q;
    captureEn    = 1'b0;
    case (state_q)
      IDLE: begin
        loadCount_d = '0;
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        if (coeffEnableD_q) begin
          captureEn   = 1'b1;
          loadCount_d = loadCount_q + 1'b1;
          if (loadCount_q == LAST_IDX) begin
            if (coeffSetFlag) begin
              state_d = RUN;
            end else begin
              state_d      = ERROR;
              coeffError_d = 1'b1;
            end
          end else if (coeffSetFlag) begin
            state_d      = ERROR;
            coeffError_d = 1'b1;
          end
        end
      end
      RUN:     state_d = RUN;
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d      = IDLE;
      captureEn    = 1'b0;
      loadCount_d  = '0;
      coeffError_d = coeffError_q;
    end
  end

  // State and control registers; coeffError is cleared only by reset.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q        <= IDLE;
      loadCount_q    <= '0;
      coeffEnableD_q <= 1'b0;
      coeffError_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      loadCount_q    <= loadCount_d;
      coeffEnableD_q <= coeffEnable;
      coeffError_q   <= coeffError_d;
    end
  end

  // Coefficient bank. It survives an abort and is simply overwritten on the
  // next load.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      for (int k = 0; k < LENGTH; k++) coeff_q[k] <= '0;
    end else begin
      for (int k = 0; k < LENGTH; k++) begin
        if (captureEn && (loadCount_q == CNT_W'(k))) coeff_q[k] <= coeffIn;
      end
    end
  end

  // Delay line and product stage. The centre tap travels alongside the
  // products so dataDelayedOut stays aligned even when samples arrive
  // back to back.
  always_ff @(posedge clock) begin
    if (!resetN || !enable) begin
      for (int k = 0; k < LENGTH; k++) begin
        tap_q[k]  <= '0;
        prod_q[k] <= '0;
      end
      midTap_q    <= '0;
      tapValid_q  <= 1'b0;
      prodValid_q <= 1'b0;
    end else begin
      tapValid_q  <= accept;
      prodValid_q <= tapValid_q;
      if (accept) begin
        tap_q[0] <= dataIn;
        for (int k = 1; k < LENGTH; k++) tap_q[k] <= tap_q[k-1];
      end
      if (tapValid_q) begin
        for (int k = 0; k < LENGTH; k++) begin
          prod_q[k] <= PROD_W'(coeff_q[k]) * PROD_W'(tap_q[k]);
        end
        midTap_q <= tap_q[CENTER];
      end
    end
  end

  // Full-precision adder tree; ACC_WIDTH has enough guard bits that the sum
  // cannot wrap.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LENGTH; k++) sum_d = sum_d + ACC_WIDTH'(prod_q[k]);
  end

  // Output stage. The data registers hold their last result between valid
  // cycles; only the valid flag is cleared by an abort.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      dataOut_q      <= '0;
      dataDelayed_q  <= '0;
      dataOutValid_q <= 1'b0;
    end else if (!enable) begin
      dataOutValid_q <= 1'b0;
    end else begin
      dataOutValid_q <= prodValid_q;
      if (prodValid_q) begin
        dataOut_q     <= sum_d;
        dataDelayed_q <= midTap_q;
      end
    end
  end

endmodule

// File: tb/tb_hilbert_fir_filter.sv
// ---------------------------------------------------------------------------
// tb_hilbert_fir_filter
//
// Self-checking bench for hilbert_fir_filter. A behavioural model of the
// coefficient setup block feeds a fixed antisymmetric tap set. Each accepted
// sample pushes its expected result onto a scoreboard queue, and a monitor
// pops and compares one entry per dataOutValid, including the two-cycle
// latency.
// ---------------------------------------------------------------------------
module tb_hilbert_fir_filter;

  localparam int LENGTH = 27;
  localparam int DW     = 18;
  localparam int AW     = 41;
  localparam int CENTER = (LENGTH - 1) / 2;

  localparam int COEF [LENGTH] = '{
    -25, 0, -51, 0, -98, 0, -180, 0, -330, 0, -650, 0, -2000, 0,
    2000, 0, 650, 0, 330, 0, 180, 0, 98, 0, 51, 0, 25
  };

  logic                 clock = 1'b0;
  logic                 resetN;
  logic                 enable;
  logic                 coeffEnable;
  logic signed [DW-1:0] coeffIn = '0;
  logic                 coeffSetFlag = 1'b0;
  logic signed [DW-1:0] dataIn;
  logic                 dataInValid;
  logic signed [AW-1:0] dataOut;
  logic signed [DW-1:0] dataDelayedOut;
  logic                 dataOutValid;
  logic                 filterReady;
  logic                 coeffError;

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  bit tbRunning = 1'b0;
  int forceFlagAt = -1;

  typedef struct {
    longint expOut;
    longint expDelayed;
    int     acceptEdge;
  } exp_t;

  exp_t   expQ[$];
  longint hist [LENGTH];

  hilbert_fir_filter #(
    .LENGTH(LENGTH), .DATA_WIDTH(DW), .ACC_WIDTH(AW)
  ) dut (
    .clock(clock),
    .resetN(resetN),
    .enable(enable),
    .coeffEnable(coeffEnable),
    .coeffIn(coeffIn),
    .coeffSetFlag(coeffSetFlag),
    .dataIn(dataIn),
    .dataInValid(dataInValid),
    .dataOut(dataOut),
    .dataDelayedOut(dataDelayedOut),
    .dataOutValid(dataOutValid),
    .filterReady(filterReady),
    .coeffError(coeffError)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount++;

  // Setup-block model: one cycle after it sees its enable it starts streaming
  // c[0], c[1], ... and raises the flag with the last coefficient (or at
  // forceFlagAt to emulate a malformed stream).
  initial begin
    int  setupIdx;
    bit  enPrev;
    setupIdx = 0;
    enPrev   = 1'b0;
    forever begin
      @(negedge clock);
      if (enPrev) begin
        coeffIn      = (setupIdx < LENGTH) ? DW'(COEF[setupIdx]) : '0;
        coeffSetFlag = (setupIdx == LENGTH - 1) || (setupIdx == forceFlagAt);
        setupIdx++;
      end else begin
        setupIdx     = 0;
        coeffSetFlag = 1'b0;
        coeffIn      = '0;
      end
      enPrev = coeffEnable;
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < LENGTH; k++) hist[k] = 0;
  endtask

  task automatic pushExpected(input int x);
    exp_t   e;
    longint acc;
    for (int k = LENGTH - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    acc = 0;
    for (int k = 0; k < LENGTH; k++) acc += longint'(COEF[k]) * hist[k];
    e.expOut     = acc;
    e.expDelayed = hist[CENTER];
    e.acceptEdge = cycleCount + 1;
    expQ.push_back(e);
  endtask

  // Drive one cycle of input from a negedge and advance to the next negedge.
  task automatic applyStimulus(input bit valid, input int x);
    logic [31:0] xv;
    xv          = x;
    dataInValid = valid;
    dataIn      = xv[DW-1:0];
    if (valid && tbRunning) pushExpected(x);
    @(negedge clock);
  endtask

  task automatic waitForReady(output int edges);
    edges = 0;
    while (!filterReady && edges < 100) begin
      @(negedge clock);
      edges++;
    end
  endtask

  // Monitor: every presented output must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (dataOutValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got dataOut=%0d, expected no output (cycle %0d)",
                   dataOut, cycleCount);
        end else begin
          e = expQ.pop_front();
          checkOutput("dataOut", longint'(dataOut), e.expOut);
          checkOutput("dataDelayedOut", longint'(dataDelayedOut), e.expDelayed);
          checkOutput("latency", longint'(cycleCount - e.acceptEdge), 2);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    clearModel();
    resetN      = 1'b0;
    enable      = 1'b0;
    dataIn      = '0;
    dataInValid = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] reset state");
    checkOutput("rst_coeffEnable", longint'(coeffEnable), 0);
    checkOutput("rst_filterReady", longint'(filterReady), 0);
    checkOutput("rst_dataOutValid", longint'(dataOutValid), 0);
    checkOutput("rst_coeffError", longint'(coeffError), 0);
    checkOutput("rst_dataOut", longint'(dataOut), 0);
    checkOutput("rst_dataDelayedOut", longint'(dataDelayedOut), 0);
    resetN = 1'b1;

    // Samples offered outside RUN must be ignored (monitor flags any output).
    dataInValid = 1'b1;
    dataIn      = 18'sd777;
    repeat (2) @(negedge clock);

    $display("[TB] coefficient load");
    enable = 1'b1;
    @(negedge clock);
    checkOutput("load_coeffEnable_after_E0", longint'(coeffEnable), 1);
    checkOutput("load_filterReady_early", longint'(filterReady), 0);
    waitForReady(edges);
    checkOutput("load_ready_edge", longint'(edges), 28);
    checkOutput("load_coeffEnable_done", longint'(coeffEnable), 0);
    checkOutput("load_coeffError", longint'(coeffError), 0);
    dataInValid = 1'b0;
    tbRunning   = 1'b1;

    $display("[TB] impulse");
    applyStimulus(1'b1, 1000);
    for (int i = 0; i < LENGTH - 1; i++) applyStimulus(1'b1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0);
    checkOutput("hold_dataOut", longint'(dataOut), 25000);
    checkOutput("hold_dataDelayedOut", longint'(dataDelayedOut), 0);
    checkOutput("hold_dataOutValid", longint'(dataOutValid), 0);

    $display("[TB] DC");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0);

    $display("[TB] gapped impulse");
    for (int i = 0; i < LENGTH; i++) applyStimulus(1'b1, 0);
    for (int j = 0; j < 2 * LENGTH; j++) applyStimulus((j % 2) == 0, (j == 0) ? 1000 : 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0);

    $display("[TB] full scale");
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, ((i % 2) == 0) ? 131071 : -131072);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0);

    $display("[TB] abort mid-RUN");
    applyStimulus(1'b1, 500);
    applyStimulus(1'b1, -700);
    applyStimulus(1'b1, 900);
    dataInValid = 1'b0;
    enable      = 1'b0;
    // Results accepted on the last two edges are flushed by the abort.
    while (expQ.size() > 0 && expQ[$].acceptEdge >= cycleCount - 1) void'(expQ.pop_back());
    tbRunning = 1'b0;
    clearModel();
    @(negedge clock);
    checkOutput("abort_filterReady", longint'(filterReady), 0);
    checkOutput("abort_dataOutValid", longint'(dataOutValid), 0);
    checkOutput("abort_coeffEnable", longint'(coeffEnable), 0);
    repeat (4) @(negedge clock);
    enable = 1'b1;
    @(negedge clock);
    checkOutput("reload_coeffEnable", longint'(coeffEnable), 1);
    waitForReady(edges);
    checkOutput("reload_ready_edge", longint'(edges), 28);
    tbRunning = 1'b1;
    applyStimulus(1'b1, -2);
    for (int i = 0; i < LENGTH - 1; i++) applyStimulus(1'b1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0);
    checkOutput("reload_last_dataOut", longint'(dataOut), -50);
    tbRunning = 1'b0;

    $display("[TB] reset mid-LOAD");
    enable = 1'b0;
    @(negedge clock);
    enable = 1'b1;
    repeat (5) @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    checkOutput("rstload_coeffEnable", longint'(coeffEnable), 0);
    checkOutput("rstload_filterReady", longint'(filterReady), 0);
    checkOutput("rstload_dataOutValid", longint'(dataOutValid), 0);
    checkOutput("rstload_dataOut", longint'(dataOut), 0);
    checkOutput("rstload_dataDelayedOut", longint'(dataDelayedOut), 0);
    checkOutput("rstload_coeffError", longint'(coeffError), 0);
    enable = 1'b0;
    resetN = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] early last-coefficient flag");
    forceFlagAt = 10;
    enable      = 1'b1;
    @(negedge clock);
    edges = 0;
    while (!coeffError && edges < 100) begin
      @(negedge clock);
      edges++;
    end
    checkOutput("err_edge", longint'(edges), 12);
    checkOutput("err_coeffError", longint'(coeffError), 1);
    checkOutput("err_coeffEnable", longint'(coeffEnable), 0);
    checkOutput("err_filterReady", longint'(filterReady), 0);
    forceFlagAt = -1;
    enable      = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("err_sticky", longint'(coeffError), 1);
    checkOutput("err_idle_coeffEnable", longint'(coeffEnable), 0);

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_empty", longint'(expQ.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
